// File: rtl/ni_pkg.sv
// Shared register map, response codes and FSM state types for the NI AXI4-Lite
// receive endpoint (ni_axil_rx) and its FIFO.
package ni_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_THRESH  = 2'd2;
  localparam logic [1:0] REG_DROPCNT = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  function automatic logic [31:0] status_word(input logic [7:0] count,
                                              input logic       full,
                                              input logic       empty);
    return {8'h00, count, 14'h0000, full, empty};
  endfunction

endpackage

// File: rtl/ni_axil_rx_if.sv
// AXI4-Lite bus bundle between a remote initiator (master) and the NI receive
// endpoint (slave).
interface ni_axil_rx_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/ni_rx_fifo.sv
// Synchronous show-ahead FIFO: read_data always presents the head word (zero when
// empty); registered count/full/empty flags.
module ni_rx_fifo #(
  parameter  int DEPTH = 64,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] read_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [CW-1:0]    count_next;

  // Push looks only at this cycle's full flag; a same-cycle pop frees no space early.
  assign push_ok    = push && !full;
  assign pop_ok     = pop && !empty;
  assign count_next = count + CW'(push_ok) - CW'(pop_ok);

  // NOTE: storage is deliberately not reset and uses non-blocking writes like all
  // sequential state; the empty flag masks stale contents on read_data.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  assign read_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ni_axil_rx.sv
// NI AXI4-Lite receive endpoint: remote DATA writes land in a show-ahead FIFO the core drains.
// Define NI_RX_DROP_EN to drop and count DATA writes hitting a full FIFO instead of stalling them.
module ni_axil_rx
  import ni_pkg::*;
#(
  parameter  int DEPTH  = 64,
  parameter  int ADDR_W = 32,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  ni_axil_rx_if.slave   s,
  output logic [31:0]   core_read_data,
  input  logic          core_read_en,
  output logic          core_empty,
  output logic          core_full,
  output logic          core_thresh,
  output logic [CW-1:0] core_count
);

  w_state_t      w_state;
  r_state_t      r_state;
  logic          aw_held;
  logic          w_held;
  logic [1:0]    aw_sel;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;
  logic [CW-1:0] thresh_reg;

  logic          commit;
  logic          push;
  logic          thresh_we;
  logic [1:0]    commit_resp;
  logic [31:0]   rd_value;
  logic [1:0]    rd_resp;

`ifdef NI_RX_DROP_EN
  logic [15:0]   drop_cnt;
  logic          drop;
  logic          drop_clr;
`endif

  // The address window is decoded upstream; only the register index bits matter here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s.awaddr[ADDR_W-1:4], s.awaddr[1:0],
                              s.araddr[ADDR_W-1:4], s.araddr[1:0]};

  ni_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (w_data),
    .pop       (core_read_en),
    .read_data (core_read_data),
    .count     (core_count),
    .full      (core_full),
    .empty     (core_empty)
  );

  assign s.awready = (w_state == W_IDLE) && !aw_held;
  assign s.wready  = (w_state == W_IDLE) && !w_held;
  assign s.arready = (r_state == R_IDLE);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    commit      = 1'b0;
    push        = 1'b0;
    thresh_we   = 1'b0;
    commit_resp = RESP_SLVERR;
`ifdef NI_RX_DROP_EN
    drop        = 1'b0;
    drop_clr    = 1'b0;
`endif
    if (w_state == W_IDLE && aw_held && w_held) begin
      commit = 1'b1;
      case (aw_sel)
        REG_DATA: begin
          if (w_strb == 4'hF) begin
            if (!core_full) begin
              push        = 1'b1;
              commit_resp = RESP_OKAY;
            end else begin
`ifdef NI_RX_DROP_EN
              drop = 1'b1;
`else
              commit = 1'b0;  // hold AW/W until the core frees a slot
`endif
            end
          end
        end
        REG_THRESH: begin
          thresh_we   = w_strb[0];
          commit_resp = RESP_OKAY;
        end
`ifdef NI_RX_DROP_EN
        REG_DROPCNT: begin
          drop_clr    = 1'b1;
          commit_resp = RESP_OKAY;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_state    <= W_IDLE;
      aw_held    <= 1'b0;
      w_held     <= 1'b0;
      aw_sel     <= '0;
      w_data     <= '0;
      w_strb     <= '0;
      s.bvalid   <= 1'b0;
      s.bresp    <= RESP_OKAY;
      thresh_reg <= CW'(DEPTH / 2);
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s.awvalid && !aw_held) begin
            aw_held <= 1'b1;
            aw_sel  <= s.awaddr[3:2];
          end
          if (s.wvalid && !w_held) begin
            w_held <= 1'b1;
            w_data <= s.wdata;
            w_strb <= s.wstrb;
          end
          if (commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            s.bvalid <= 1'b1;
            s.bresp  <= commit_resp;
            w_state  <= W_RESP;
            if (thresh_we) thresh_reg <= w_data[CW-1:0];
          end
        end
        W_RESP: begin
          if (s.bready) begin
            s.bvalid <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_value = '0;
    rd_resp  = RESP_OKAY;
    case (s.araddr[3:2])
      REG_STATUS:  rd_value = status_word(8'(core_count), core_full, core_empty);
      REG_THRESH:  rd_value = 32'(thresh_reg);
`ifdef NI_RX_DROP_EN
      REG_DROPCNT: rd_value = {16'h0000, drop_cnt};
`endif
      default:     rd_resp  = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= R_IDLE;
      s.rvalid <= 1'b0;
      s.rdata  <= '0;
      s.rresp  <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s.arvalid) begin
            s.rdata  <= rd_value;
            s.rresp  <= rd_resp;
            s.rvalid <= 1'b1;
            r_state  <= R_RESP;
          end
        end
        R_RESP: begin
          if (s.rready) begin
            s.rvalid <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

`ifdef NI_RX_DROP_EN
  always_ff @(posedge clk) begin
    if (!reset)                              drop_cnt <= '0;
    else if (drop_clr)                       drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF)   drop_cnt <= drop_cnt + 16'd1;
  end
`endif

  // Interrupt follows the registered count by one cycle; a zero threshold disables it.
  always_ff @(posedge clk) begin
    if (!reset) core_thresh <= 1'b0;
    else        core_thresh <= (thresh_reg != '0) && (core_count >= thresh_reg);
  end

endmodule

// File: tb/tb_ni_axil_rx.sv
// Bench for ni_axil_rx: directed scenarios plus randomized register/FIFO traffic
// compared against a queue-based model of the receive path.
module tb_ni_axil_rx;
  import ni_pkg::*;

  localparam int DEPTH = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   core_read_data;
  logic          core_read_en = 1'b0;
  logic          core_empty;
  logic          core_full;
  logic          core_thresh;
  logic [CW-1:0] core_count;

  ni_axil_rx_if #(.ADDR_W(32)) s ();

  ni_axil_rx #(
    .DEPTH  (DEPTH),
    .ADDR_W (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .s              (s),
    .core_read_data (core_read_data),
    .core_read_en   (core_read_en),
    .core_empty     (core_empty),
    .core_full      (core_full),
    .core_thresh    (core_thresh),
    .core_count     (core_count)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] model_q[$];
  int          thr   = DEPTH / 2;
  int          drops = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives AW and W independently; returns just after the edge of the last handshake.
  task automatic wr_issue(input logic [1:0] idx, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly);
    bit          aw_done = 1'b0;
    bit          w_done  = 1'b0;
    bit          aw_hs;
    bit          w_hs;
    int          t = 0;
    logic [31:0] a = $urandom();
    a[3:2] = idx;
    while (!(aw_done && w_done) && t < 64) begin
      s.awaddr  = a;
      s.awvalid = !aw_done && (t >= aw_dly);
      s.wdata   = data;
      s.wstrb   = strb;
      s.wvalid  = !w_done && (t >= w_dly);
      aw_hs     = s.awvalid && s.awready;
      w_hs      = s.wvalid && s.wready;
      tick();
      aw_done   = aw_done || aw_hs;
      w_done    = w_done || w_hs;
      t++;
    end
    s.awvalid = 1'b0;
    s.wvalid  = 1'b0;
    check("aw_w_accept", 32'(aw_done && w_done), 32'd1);
  endtask

  task automatic wait_b(input int dly, output logic [1:0] resp);
    bit got = 1'b0;
    resp = 2'b11;
    repeat (dly) tick();
    s.bready = 1'b1;
    for (int i = 0; i < 64 && !got; i++) begin
      if (s.bvalid) begin
        resp = s.bresp;
        got  = 1'b1;
      end
      tick();
    end
    s.bready = 1'b0;
    check("b_arrived", 32'(got), 32'd1);
  endtask

  task automatic axi_write(input logic [1:0] idx, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    wr_issue(idx, data, strb, $urandom_range(0, 3), $urandom_range(0, 3));
    wait_b($urandom_range(0, 2), resp);
  endtask

  task automatic axi_read(input logic [1:0] idx, output logic [31:0] data,
                          output logic [1:0] resp);
    bit          done = 1'b0;
    logic [31:0] a = $urandom();
    a[3:2]    = idx;
    data      = '1;
    resp      = 2'b11;
    s.araddr  = a;
    s.arvalid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      done = s.arready;
      tick();
    end
    s.arvalid = 1'b0;
    check("ar_accept", 32'(done), 32'd1);
    done      = 1'b0;
    s.rready  = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      if (s.rvalid) begin
        data = s.rdata;
        resp = s.rresp;
        done = 1'b1;
      end
      tick();
    end
    s.rready = 1'b0;
    check("r_arrived", 32'(done), 32'd1);
  endtask

  // Model of a register read, straight from the register map.
  task automatic expect_read(input logic [1:0] idx, output logic [31:0] data,
                             output logic [1:0] resp);
    int n = model_q.size();
    data = '0;
    resp = RESP_OKAY;
    case (idx)
      REG_STATUS: data = {8'h00, 8'(n), 14'h0, n == DEPTH, n == 0};
      REG_THRESH: data = 32'(thr);
`ifdef NI_RX_DROP_EN
      REG_DROPCNT: data = 32'(drops);
`endif
      default: resp = RESP_SLVERR;
    endcase
  endtask

  task automatic pop_check(input string tag);
    check({tag, "_head"}, core_read_data, model_q[0]);
    core_read_en = 1'b1;
    tick();
    core_read_en = 1'b0;
    void'(model_q.pop_front());
  endtask

  task automatic settle_check(input string tag);
    int n;
    tick();
    tick();
    n = model_q.size();
    check({tag, "_count"}, 32'(core_count), 32'(n));
    check({tag, "_empty"}, 32'(core_empty), 32'(n == 0));
    check({tag, "_full"}, 32'(core_full), 32'(n == DEPTH));
    check({tag, "_thresh"}, 32'(core_thresh), 32'(thr != 0 && n >= thr));
    check({tag, "_rdata"}, core_read_data, (n == 0) ? 32'h0 : model_q[0]);
  endtask

  task automatic push_word(input logic [31:0] w);
    logic [1:0] resp;
    axi_write(REG_DATA, w, 4'hF, resp);
    check("push_resp", 32'(resp), 32'(RESP_OKAY));
    model_q.push_back(w);
  endtask

  task automatic drain(input string tag);
    while (model_q.size() > 0) pop_check(tag);
    settle_check(tag);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] ed;
    logic [1:0]  er;
    logic [31:0] w;
    logic [3:0]  strb;
    int          seen;

    s.awaddr = '0; s.awvalid = 1'b0; s.wdata = '0; s.wstrb = '0; s.wvalid = 1'b0;
    s.bready = 1'b0; s.araddr = '0; s.arvalid = 1'b0; s.rready = 1'b0;

    // Reset values
    repeat (2) tick();
    check("rst_awready", 32'(s.awready), 32'd1);
    check("rst_wready", 32'(s.wready), 32'd1);
    check("rst_bvalid", 32'(s.bvalid), 32'd0);
    check("rst_bresp", 32'(s.bresp), 32'd0);
    check("rst_arready", 32'(s.arready), 32'd1);
    check("rst_rvalid", 32'(s.rvalid), 32'd0);
    check("rst_rdata", s.rdata, 32'd0);
    check("rst_rresp", 32'(s.rresp), 32'd0);
    check("rst_empty", 32'(core_empty), 32'd1);
    check("rst_full", 32'(core_full), 32'd0);
    check("rst_thresh", 32'(core_thresh), 32'd0);
    check("rst_count", 32'(core_count), 32'd0);
    check("rst_rd_data", core_read_data, 32'd0);
    reset = 1'b1;
    tick();
    axi_read(REG_THRESH, d, r);
    check("rst_thresh_reg", d, 32'(DEPTH / 2));

    // AW first, W three cycles later
    wr_issue(REG_DATA, 32'hDEAD_BEEF, 4'hF, 0, 3);
    wait_b(0, r);
    check("t1_bresp", 32'(r), 32'(RESP_OKAY));
    model_q.push_back(32'hDEAD_BEEF);
    settle_check("t1");
    pop_check("t1_pop");
    settle_check("t1_after_pop");

    // Threshold rises one cycle after the count reaches it, falls one cycle after a pop
    axi_write(REG_THRESH, 32'd4, 4'h1, r);
    check("t2_thresh_resp", 32'(r), 32'(RESP_OKAY));
    thr = 4;
    for (int i = 0; i < 3; i++) push_word(32'h1000 + 32'(i));
    settle_check("t2_three");
    wr_issue(REG_DATA, 32'h1003, 4'hF, 0, 0);
    model_q.push_back(32'h1003);
    tick();
    check("t2_count4", 32'(core_count), 32'd4);
    check("t2_thresh_lag", 32'(core_thresh), 32'd0);
    tick();
    check("t2_thresh_rise", 32'(core_thresh), 32'd1);
    wait_b(0, r);
    check("t2_bresp", 32'(r), 32'(RESP_OKAY));
    pop_check("t2_pop");
    check("t2_thresh_hold", 32'(core_thresh), 32'd1);
    tick();
    check("t2_thresh_fall", 32'(core_thresh), 32'd0);
    drain("t2_drain");

    // STATUS layout and error responses
    for (int i = 0; i < 3; i++) push_word($urandom());
    axi_read(REG_STATUS, d, r);
    check("t5_status", d, 32'h0003_0000);
    check("t5_status_resp", 32'(r), 32'(RESP_OKAY));
    axi_read(REG_DATA, d, r);
    check("t5_rd_data_val", d, 32'd0);
    check("t5_rd_data_resp", 32'(r), 32'(RESP_SLVERR));
    axi_write(REG_STATUS, 32'hFFFF_FFFF, 4'hF, r);
    check("t5_wr_status_resp", 32'(r), 32'(RESP_SLVERR));
    settle_check("t5_wr_status");
    axi_read(REG_THRESH, d, r);
    check("t5_thresh_kept", d, 32'(thr));
    axi_write(REG_DATA, 32'hBAD0_0003, 4'h3, r);
    check("t5_partial_resp", 32'(r), 32'(RESP_SLVERR));
    settle_check("t5_partial");
    drain("t5_drain");

    // Push and pop in the same cycle at count 10, across pointer wrap
    for (int i = 0; i < 10; i++) push_word($urandom());
    for (int i = 0; i < 200; i++) begin
      w = $urandom();
      wr_issue(REG_DATA, w, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2));
      check("t4_head", core_read_data, model_q[0]);
      core_read_en = 1'b1;
      tick();
      core_read_en = 1'b0;
      void'(model_q.pop_front());
      model_q.push_back(w);
      check("t4_count", 32'(core_count), 32'(model_q.size()));
      wait_b(0, r);
      check("t4_bresp", 32'(r), 32'(RESP_OKAY));
    end
    drain("t4_drain");

    // Full FIFO: 65th DATA write
    for (int i = 0; i < DEPTH; i++) push_word(32'hF00D_0000 + 32'(i));
    settle_check("t3_full");
    wr_issue(REG_DATA, 32'hF00D_0065, 4'hF, 0, 0);
`ifdef NI_RX_DROP_EN
    wait_b(0, r);
    check("t3_drop_resp", 32'(r), 32'(RESP_SLVERR));
    drops++;
    settle_check("t3_drop");
    axi_read(REG_DROPCNT, d, r);
    check("t3_dropcnt", d, 32'(drops));
    check("t3_dropcnt_resp", 32'(r), 32'(RESP_OKAY));
    axi_write(REG_DROPCNT, 32'd0, 4'h0, r);
    check("t3_dropclr_resp", 32'(r), 32'(RESP_OKAY));
    drops = 0;
    axi_read(REG_DROPCNT, d, r);
    check("t3_dropcnt_clr", d, 32'(drops));
`else
    s.bready = 1'b1;
    seen = 0;
    repeat (10) begin
      tick();
      if (s.bvalid) seen++;
    end
    s.bready = 1'b0;
    check("t3_stall_bvalid", 32'(seen), 32'd0);
    check("t3_stall_full", 32'(core_full), 32'd1);
    pop_check("t3_pop");
    wait_b(0, r);
    check("t3_release_resp", 32'(r), 32'(RESP_OKAY));
    model_q.push_back(32'hF00D_0065);
    settle_check("t3_release");
`endif
    drain("t3_drain");

    // Randomized traffic
    for (int n = 0; n < 160; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          if (model_q.size() == DEPTH) begin
            pop_check("rnd_pop_full");
          end else begin
            w    = $urandom();
            strb = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            axi_write(REG_DATA, w, strb, r);
            er = (strb == 4'hF) ? RESP_OKAY : RESP_SLVERR;
            if (strb == 4'hF) model_q.push_back(w);
            check("rnd_data_resp", 32'(r), 32'(er));
          end
        end
        4, 5: begin
          if (model_q.size() > 0) begin
            pop_check("rnd_pop");
          end else begin
            core_read_en = 1'b1;
            tick();
            core_read_en = 1'b0;
          end
        end
        6, 8: begin
          axi_read(2'($urandom_range(0, 3)), d, r);
          expect_read(s.araddr[3:2], ed, er);
          check("rnd_rdata", d, ed);
          check("rnd_rresp", 32'(r), 32'(er));
        end
        7: begin
          w    = 32'($urandom_range(0, 80));
          strb = 4'($urandom_range(0, 15));
          axi_write(REG_THRESH, w, strb, r);
          if (strb[0]) thr = int'(w) % (1 << CW);
          check("rnd_thresh_resp", 32'(r), 32'(RESP_OKAY));
        end
        default: begin
          axi_write(($urandom_range(0, 1) == 0) ? REG_STATUS : REG_DROPCNT, $urandom(), 4'hF, r);
`ifdef NI_RX_DROP_EN
          if (s.awaddr[3:2] == REG_DROPCNT) drops = 0;
          er = (s.awaddr[3:2] == REG_DROPCNT) ? RESP_OKAY : RESP_SLVERR;
`else
          er = RESP_SLVERR;
`endif
          check("rnd_misc_resp", 32'(r), 32'(er));
        end
      endcase
      settle_check("rnd");
    end
    drain("rnd_drain");

    // Reset while both response channels hold a pending response
    for (int i = 0; i < 5; i++) push_word($urandom());
    wr_issue(REG_THRESH, 32'd9, 4'h1, 0, 0);
    s.araddr  = 32'h0000_0004;
    s.arvalid = 1'b1;
    tick();
    s.arvalid = 1'b0;
    repeat (3) tick();
    check("t6_pre_bvalid", 32'(s.bvalid), 32'd1);
    check("t6_pre_rvalid", 32'(s.rvalid), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_q.delete();
    thr = DEPTH / 2;
    check("t6_bvalid", 32'(s.bvalid), 32'd0);
    check("t6_rvalid", 32'(s.rvalid), 32'd0);
    check("t6_awready", 32'(s.awready), 32'd1);
    check("t6_arready", 32'(s.arready), 32'd1);
    check("t6_count", 32'(core_count), 32'd0);
    check("t6_empty", 32'(core_empty), 32'd1);
    check("t6_rd_data", core_read_data, 32'd0);
    tick();
    axi_read(REG_THRESH, d, r);
    check("t6_thresh_reg", d, 32'(thr));
    settle_check("t6_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
